// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if
// Bundles the controller <-> datapath signals of the multicycle MIPS core.
//   Opcode, Funct : instruction register fields IR[31:26], IR[5:0]
//   Zero          : ALU zero flag (combinational from the datapath)
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//   ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn : datapath selects / enables
//   state         : current controller state code (debug)
// modport master : controller side (drives the selects and enables)
// modport slave  : datapath side (drives Opcode/Funct/Zero)
// ---------------------------------------------------------------------------
interface multicycle_controller_if;
   logic [5:0] Opcode;
   logic [5:0] Funct;
   logic       Zero;
   logic       IorD;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUControl;
   logic [1:0] PCSrc;
   logic       PCEn;
   logic [3:0] state;

   modport master (
      input  Opcode, Funct, Zero,
      output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
             ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, state
   );

   modport slave (
      output Opcode, Funct, Zero,
      input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
             ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, state
   );
endinterface

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Moore sequencing FSM for the multicycle MIPS datapath. Each instruction is
// walked through FETCH/DECODE and an opcode-specific tail, one state per
// clock. All datapath selects and write enables come from here.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (also masks the write enables)
//   bus : multicycle_controller_if.master (Opcode/Funct/Zero in, controls out)
// ---------------------------------------------------------------------------
module multicycle_controller (
   input  logic                   clk,
   input  logic                   rst,
   multicycle_controller_if.master bus
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      ADDIEX = 4'd9,
      ADDIWB = 4'd10,
      JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Per-state control word. pcwrite/branch are combined with Zero at the
   // output; funct_alu hands ALUControl over to the Funct decoder in EXEC.
   typedef struct packed {
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [2:0] alucontrol;
      logic [1:0] pcsrc;
      logic       pcwrite;
      logic       branch;
      logic       funct_alu;
   } ctrl_t;

   state_t state_q;
   ctrl_t  ctrl_q;

   function automatic state_t next_state(state_t s, logic [5:0] opcode);
      state_t n;
      n = FETCH;
      case (s)
         FETCH:  n = DECODE;
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: n = MEMADR;
               OP_RTYPE:     n = EXEC;
               OP_BEQ:       n = BRANCH;
               OP_ADDI:      n = ADDIEX;
               OP_J:         n = JUMP;
               default:      n = FETCH;   // unknown opcode runs as a NOP
            endcase
         end
         MEMADR: n = (opcode == OP_SW) ? MEMWR : MEMRD;
         MEMRD:  n = MEMWB;
         EXEC:   n = ALUWB;
         ADDIEX: n = ADDIWB;
         default: n = FETCH;              // terminal states and codes 12-15
      endcase
      return n;
   endfunction

   function automatic ctrl_t ctrl_for(state_t s);
      ctrl_t c;
      // NOTE: every field gets a value before the case, so no path can leave
      // one unassigned and infer a latch once this is used combinationally.
      c = '0;
      case (s)
         FETCH: begin
            c.alusrcb    = 2'b01;
            c.alucontrol = ALU_ADD;
            c.irwrite    = 1'b1;
            c.pcwrite    = 1'b1;
         end
         DECODE: begin
            c.alusrcb    = 2'b11;     // branch target into ALUOut
            c.alucontrol = ALU_ADD;
         end
         MEMADR, ADDIEX: begin
            c.alusrca    = 1'b1;
            c.alusrcb    = 2'b10;
            c.alucontrol = ALU_ADD;
         end
         MEMRD: c.iord = 1'b1;
         MEMWR: begin
            c.iord     = 1'b1;
            c.memwrite = 1'b1;
         end
         MEMWB: begin
            c.memtoreg = 1'b1;
            c.regwrite = 1'b1;
         end
         EXEC: begin
            c.alusrca   = 1'b1;
            c.funct_alu = 1'b1;
         end
         ALUWB: begin
            c.regdst   = 1'b1;
            c.regwrite = 1'b1;
         end
         ADDIWB: c.regwrite = 1'b1;
         BRANCH: begin
            c.alusrca    = 1'b1;
            c.alucontrol = ALU_SUB;
            c.pcsrc      = 2'b01;
            c.branch     = 1'b1;
         end
         JUMP: begin
            c.pcsrc   = 2'b10;
            c.pcwrite = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

   function automatic logic [2:0] funct_to_alu(logic [5:0] funct);
      logic [2:0] a;
      a = ALU_ADD;                    // unknown Funct still adds and writes back
      case (funct)
         6'b100010: a = ALU_SUB;
         6'b100100: a = ALU_AND;
         6'b100101: a = ALU_OR;
         6'b101010: a = ALU_SLT;
         default:   a = ALU_ADD;
      endcase
      return a;
   endfunction

   // The control word is registered together with the state it belongs to,
   // so the outputs are glitch-free Moore decodes of the current state.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; blocking ones would make ordering matter.
      if (rst) begin
         state_q <= FETCH;
         ctrl_q  <= ctrl_for(FETCH);
      end else begin
         state_q <= next_state(state_q, bus.Opcode);
         ctrl_q  <= ctrl_for(next_state(state_q, bus.Opcode));
      end
   end

   // Write enables are masked by rst directly (not via the register) so an
   // instruction interrupted by reset cannot complete a write in that cycle.
   assign bus.IorD       = ctrl_q.iord;
   assign bus.MemWrite   = ctrl_q.memwrite & ~rst;
   assign bus.IRWrite    = ctrl_q.irwrite  & ~rst;
   assign bus.RegDst     = ctrl_q.regdst;
   assign bus.MemtoReg   = ctrl_q.memtoreg;
   assign bus.RegWrite   = ctrl_q.regwrite & ~rst;
   assign bus.ALUSrcA    = ctrl_q.alusrca;
   assign bus.ALUSrcB    = ctrl_q.alusrcb;
   assign bus.ALUControl = ctrl_q.funct_alu ? funct_to_alu(bus.Funct) : ctrl_q.alucontrol;
   assign bus.PCSrc      = ctrl_q.pcsrc;
   // Zero is live in BRANCH: beq resolves in the same cycle.
   assign bus.PCEn       = ~rst & (ctrl_q.pcwrite | (ctrl_q.branch & bus.Zero));
   assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
// Directed and randomized instruction streams for multicycle_controller.
// Expected state walks and control outputs come from per-opcode tables and a
// per-state output table in this file; cycle counts from a CPI table.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   multicycle_controller_if bus ();

   multicycle_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_asserts = 0;
   int n_fails   = 0;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   // Observed control outputs, packed in a fixed order for comparison.
   logic [14:0] obs_vec;
   assign obs_vec = {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
                     bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
                     bus.PCSrc, bus.PCEn};

   logic [3:0] en_vec;
   assign en_vec = {bus.IRWrite, bus.PCEn, bus.RegWrite, bus.MemWrite};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // State visited at cycle idx of an instruction; -1 once it should be over.
   function automatic int seq_at(logic [5:0] op, int idx);
      int s[6];
      case (op)
         OP_LW:   s = '{0, 1, 2, 3, 4, -1};
         OP_SW:   s = '{0, 1, 2, 5, -1, -1};
         OP_R:    s = '{0, 1, 6, 7, -1, -1};
         OP_BEQ:  s = '{0, 1, 8, -1, -1, -1};
         OP_ADDI: s = '{0, 1, 9, 10, -1, -1};
         OP_J:    s = '{0, 1, 11, -1, -1, -1};
         default: s = '{0, 1, -1, -1, -1, -1};
      endcase
      return (idx < 6) ? s[idx] : -1;
   endfunction

   function automatic int cpi(logic [5:0] op);
      case (op)
         OP_LW:                   return 5;
         OP_SW, OP_R, OP_ADDI:    return 4;
         OP_BEQ, OP_J:            return 3;
         default:                 return 2;
      endcase
   endfunction

   function automatic logic [2:0] alu_of_funct(logic [5:0] f);
      case (f)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Output table: anything a state does not mention stays 0.
   function automatic logic [14:0] exp_out(int st, logic [5:0] f, logic z);
      logic iord, mw, irw, rd, m2r, rw, asa, pcen;
      logic [1:0] asb, pcs;
      logic [2:0] alu;
      iord = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; asa = 0; pcen = 0;
      asb = 2'b00; pcs = 2'b00; alu = 3'b000;
      case (st)
         0:    begin asb = 2'b01; alu = 3'b010; irw = 1; pcen = 1; end
         1:    begin asb = 2'b11; alu = 3'b010; end
         2, 9: begin asa = 1; asb = 2'b10; alu = 3'b010; end
         3:    iord = 1;
         4:    begin m2r = 1; rw = 1; end
         5:    begin iord = 1; mw = 1; end
         6:    begin asa = 1; alu = alu_of_funct(f); end
         7:    begin rd = 1; rw = 1; end
         8:    begin asa = 1; alu = 3'b110; pcs = 2'b01; pcen = z; end
         10:   rw = 1;
         11:   begin pcs = 2'b10; pcen = 1; end
         default: ;
      endcase
      return {iord, mw, irw, rd, m2r, rw, asa, asb, alu, pcs, pcen};
   endfunction

   // Called #1 after a rising edge with the DUT in FETCH. Steps one
   // instruction, checking state and outputs at each falling edge.
   task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] f,
                            input bit rand_zero, input logic zfix);
      int cycles;
      bit done;
      cycles = 0;
      done   = 0;
      bus.Opcode = op;
      bus.Funct  = f;
      for (int i = 0; i < 8 && !done; i++) begin
         logic z;
         z = rand_zero ? 1'($urandom_range(0, 1)) : zfix;
         bus.Zero = z;
         @(negedge clk);
         check({name, ".state"}, 32'(bus.state), seq_at(op, i));
         check({name, ".out"}, 32'(obs_vec), 32'(exp_out(seq_at(op, i), f, z)));
         @(posedge clk);
         #1;
         cycles++;
         if (bus.state == 4'd0) done = 1;
      end
      check({name, ".cycles"}, cycles, cpi(op));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] ops[7];
      logic [5:0] functs[5];
      logic [5:0] bad_ops[4];
      logic [5:0] op;
      logic [5:0] f;

      ops     = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, 6'b111111};
      functs  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      bad_ops = '{6'b111111, 6'b000001, 6'b001100, 6'b100001};

      // Reset: enables masked while rst is high, state held at FETCH.
      rst = 1'b1;
      bus.Opcode = OP_LW;
      bus.Funct  = 6'b0;
      bus.Zero   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset.state", 32'(bus.state), 0);
      check("reset.enables", 32'(en_vec), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed instruction walks.
      run_instr("lw",       OP_LW,      6'b000000, 0, 1'b0);
      run_instr("sw",       OP_SW,      6'b000000, 0, 1'b0);
      run_instr("r_sub",    OP_R,       6'b100010, 0, 1'b0);
      run_instr("r_slt",    OP_R,       6'b101010, 0, 1'b0);
      run_instr("r_badfn",  OP_R,       6'b111111, 0, 1'b0);
      run_instr("addi",     OP_ADDI,    6'b000000, 0, 1'b0);
      run_instr("beq_z1",   OP_BEQ,     6'b000000, 0, 1'b1);
      run_instr("beq_z0",   OP_BEQ,     6'b000000, 0, 1'b0);
      run_instr("j",        OP_J,       6'b000000, 0, 1'b1);
      run_instr("illegal",  6'b111111,  6'b000000, 0, 1'b1);

      // Reset while in MEMWR: the store must not be written.
      bus.Opcode = OP_SW;
      bus.Zero   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("abort.in_memwr", 32'(bus.state), 5);
      rst = 1'b1;
      @(negedge clk);
      check("abort.memwrite", 32'(bus.MemWrite), 0);
      check("abort.enables", 32'(en_vec), 0);
      @(posedge clk);
      #1;
      check("abort.state", 32'(bus.state), 0);
      rst = 1'b0;
      run_instr("post_abort_lw", OP_LW, 6'b000000, 0, 1'b0);

      // Randomized instruction stream.
      for (int n = 0; n < 40; n++) begin
         op = ops[$urandom_range(0, 6)];
         if (op == 6'b111111) op = bad_ops[$urandom_range(0, 3)];
         if ($urandom_range(0, 3) == 0) f = 6'($urandom);
         else                           f = functs[$urandom_range(0, 4)];
         run_instr($sformatf("rand%0d_op%b", n, op), op, f, 1, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
